// File: rtl/seq_match_param_pkg.sv
// Shared types and constants for the streaming pattern matcher.
package seq_match_param_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
  localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  // Upper-case ASCII letters map onto their lower-case code; everything else passes through.
  function automatic logic [7:0] fold_ascii(input logic [7:0] c);
    logic [7:0] res;
    res = c;
    if ((c >= ASCII_UPPER_LO) && (c <= ASCII_UPPER_HI)) begin
      res = c | ASCII_CASE_BIT;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Combinational window comparator: the newest i_len symbols of i_win (slot 0 = newest)
// must equal pattern slots 0..i_len-1 (slot 0 = oldest), optionally case-folded.
module seq_match_cmp
  import seq_match_param_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic [MAX_LEN*DATA_W-1:0] i_win,
  input  logic [MAX_LEN*DATA_W-1:0] i_pat,
  input  logic [LEN_W-1:0]          i_len,
  input  logic                      i_nocase,
  output logic                      o_hit
);

  logic [MAX_LEN-1:0] w_ok;

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pos
      logic [DATA_W-1:0] w_sym;
      logic [DATA_W-1:0] w_ref;
      logic [DATA_W-1:0] w_sym_f;
      logic [DATA_W-1:0] w_ref_f;

      assign w_sym = i_win[gi*DATA_W +: DATA_W];

      // Window position gi (age gi) lines up with pattern slot i_len-1-gi.
      always_comb begin
        w_ref = '0;
        for (int j = 0; j < MAX_LEN; j++) begin
          if ((j + gi + 1) == int'(i_len)) begin
            w_ref = i_pat[j*DATA_W +: DATA_W];
          end
        end
      end

      if (DATA_W == 8) begin : g_fold
        assign w_sym_f = i_nocase ? fold_ascii(w_sym) : w_sym;
        assign w_ref_f = i_nocase ? fold_ascii(w_ref) : w_ref;
      end else begin : g_nofold
        assign w_sym_f = w_sym;
        assign w_ref_f = w_ref;
      end

      assign w_ok[gi] = (gi >= int'(i_len)) || (w_sym_f == w_ref_f);
    end
  endgenerate

  assign o_hit = &w_ok;

endmodule

// File: rtl/seq_match_param.sv
// Streaming sequence matcher: programmable pattern, saturating match counter,
// optional overlapping matches and ASCII case-insensitive compare.
module seq_match_param
  import seq_match_param_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(MAX_LEN),
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              en,
  input  logic              mode_overlap,
  input  logic              mode_nocase,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              check_ok,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              cfg_err
);

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0]         r_pat [MAX_LEN];
  logic [MAX_LEN*DATA_W-1:0] w_pat_flat;
  logic [MAX_LEN*DATA_W-1:0] r_hist;
  logic [MAX_LEN*DATA_W-1:0] w_win;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_fill;
  logic [LEN_W-1:0]          w_fill_inc;
  logic [CNT_W-1:0]          r_match_cnt;
  logic                      r_check_ok;
  logic                      r_cfg_err;
  logic                      w_len_bad;
  logic                      w_accept;
  logic                      w_hit;
  logic                      w_match;

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pat
      assign w_pat_flat[gi*DATA_W +: DATA_W] = r_pat[gi];
    end
  endgenerate

  // The window already contains the incoming symbol, so a match is decided on the accepting cycle.
  assign w_win      = {r_hist[(MAX_LEN-1)*DATA_W-1:0], data_in};
  assign w_fill_inc = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
  assign w_len_bad  = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
  assign w_accept   = (r_state == ST_RUN) && en && data_in_valid;
  assign w_match    = w_accept && !r_cfg_err && (w_fill_inc >= r_len) && w_hit;

  seq_match_cmp #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .i_win    (w_win),
    .i_pat    (w_pat_flat),
    .i_len    (r_len),
    .i_nocase (mode_nocase),
    .o_hit    (w_hit)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (en)  w_state_next = ST_RUN;
      ST_RUN:  if (!en) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_check_ok  <= 1'b0;
      r_match_cnt <= '0;
      r_cfg_err   <= 1'b0;
      r_len       <= '0;
      r_fill      <= '0;
      r_hist      <= '0;
      for (int k = 0; k < MAX_LEN; k++) begin
        r_pat[k] <= '0;
      end
    end else begin
      r_check_ok <= w_match;
      if (r_state == ST_IDLE) begin
        if (cfg_we) begin
          r_pat[cfg_idx] <= cfg_data;
        end
        if (en) begin
          r_len       <= cfg_len;
          r_fill      <= '0;
          r_match_cnt <= '0;
          r_cfg_err   <= w_len_bad;
        end
      end else if (!en) begin
        r_fill <= '0;
      end else if (data_in_valid) begin
        r_hist <= w_win;
        // Non-overlapping mode restarts the fill so the next match needs a fresh pattern's worth.
        r_fill <= (w_match && !mode_overlap) ? '0 : w_fill_inc;
        if (w_match && (r_match_cnt != '1)) begin
          r_match_cnt <= r_match_cnt + 1'b1;
        end
      end
    end
  end

  assign check_ok  = r_check_ok;
  assign match_cnt = r_match_cnt;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_match_param.sv
// Self-checking bench for seq_match_param: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seq_match_param;

  localparam int DW      = 8;
  localparam int ML      = 8;
  localparam int CW      = 4;
  localparam int IW      = $clog2(ML);
  localparam int LW      = $clog2(ML + 1);
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          sys_clk;
  logic          reset;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [DW-1:0] cfg_data;
  logic [LW-1:0] cfg_len;
  logic          en;
  logic          mode_overlap;
  logic          mode_nocase;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          check_ok;
  logic [CW-1:0] match_cnt;
  logic          cfg_err;

  seq_match_param #(
    .DATA_W  (DW),
    .MAX_LEN (ML),
    .CNT_W   (CW)
  ) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_data      (cfg_data),
    .cfg_len       (cfg_len),
    .en            (en),
    .mode_overlap  (mode_overlap),
    .mode_nocase   (mode_nocase),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .check_ok      (check_ok),
    .match_cnt     (match_cnt),
    .cfg_err       (cfg_err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference model: accepted symbols since arm/flush, pattern, latched length.
  bit         m_seen = 0;
  bit         m_run;
  bit         m_ok;
  bit         m_err;
  int         m_len;
  int         m_cnt;
  logic [7:0] m_pat [ML];
  logic [7:0] m_q [$];

  function automatic logic [7:0] lc(input logic [7:0] c);
    if (mode_nocase && (c >= 8'h41) && (c <= 8'h5A)) return c + 8'h20;
    return c;
  endfunction

  function automatic bit tail_matches();
    int base;
    base = m_q.size() - m_len;
    for (int j = 0; j < m_len; j++) begin
      if (lc(m_q[base + j]) != lc(m_pat[j])) return 1'b0;
    end
    return 1'b1;
  endfunction

  // At each falling edge: compare outputs, then advance the model with the inputs the next rising edge samples.
  initial begin
    bit ok;
    forever begin
      @(negedge sys_clk);
      if (m_seen) begin
        chk("cyc_check_ok", check_ok, m_ok);
        chk("cyc_match_cnt", match_cnt, m_cnt);
        chk("cyc_cfg_err", cfg_err, m_err);
        if (check_ok === 1'b1) pulses++;
      end
      if (reset) begin
        m_seen = 1;
        m_run  = 0;
        m_ok   = 0;
        m_err  = 0;
        m_len  = 0;
        m_cnt  = 0;
        m_q.delete();
        for (int i = 0; i < ML; i++) m_pat[i] = 8'h00;
      end else if (m_seen) begin
        ok = 0;
        if (!m_run) begin
          if (cfg_we) m_pat[cfg_idx] = cfg_data;
          if (en) begin
            m_run = 1;
            m_len = int'(cfg_len);
            m_err = (m_len == 0) || (m_len > ML);
            m_cnt = 0;
            m_q.delete();
          end
        end else if (!en) begin
          m_run = 0;
          m_q.delete();
        end else if (data_in_valid) begin
          m_q.push_back(data_in);
          if (m_q.size() > ML) void'(m_q.pop_front());
          if (!m_err && (m_q.size() >= m_len) && tail_matches()) begin
            ok = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (!mode_overlap) m_q.delete();
          end
        end
        m_ok = ok;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) begin
      cfg_we   = 1'b1;
      cfg_idx  = IW'(i);
      cfg_data = s[i];
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic arm(input int len);
    cfg_len = LW'(len);
    en      = 1'b1;
    tick();
  endtask

  task automatic disarm();
    en = 1'b0;
    tick();
  endtask

  task automatic stream(input string s);
    for (int i = 0; i < s.len(); i++) begin
      data_in       = s[i];
      data_in_valid = 1'b1;
      tick();
    end
    data_in_valid = 1'b0;
  endtask

  task automatic stream_byte(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      data_in       = b;
      data_in_valid = 1'b1;
      tick();
    end
    data_in_valid = 1'b0;
  endtask

  initial begin
    int p0;
    reset = 0; cfg_we = 0; cfg_idx = '0; cfg_data = '0; cfg_len = '0;
    en = 0; mode_overlap = 0; mode_nocase = 0; data_in = '0; data_in_valid = 0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_check_ok", check_ok, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // "hhello" against "hello"
    load("hello");
    arm(5);
    p0 = pulses;
    stream("hhello");
    chk("hello_pulse", check_ok, 1);
    tick();
    chk("hello_pulse_once", check_ok, 0);
    chk("hello_cnt", match_cnt, 1);
    chk("hello_npulse", pulses - p0, 1);
    disarm();

    // "ababab" against "abab", overlapping then not
    load("abab");
    mode_overlap = 1'b1;
    arm(4);
    p0 = pulses;
    stream("ababab");
    tick();
    chk("ovl_cnt", match_cnt, 2);
    chk("ovl_npulse", pulses - p0, 2);
    disarm();
    chk("disarm_cnt_hold", match_cnt, 2);
    mode_overlap = 1'b0;
    arm(4);
    chk("arm_clears_cnt", match_cnt, 0);
    p0 = pulses;
    stream("ababab");
    tick();
    chk("noovl_cnt", match_cnt, 1);
    chk("noovl_npulse", pulses - p0, 1);
    disarm();

    // Gaps in the stream with junk on data_in
    load("hello");
    arm(5);
    p0 = pulses;
    stream("he");
    data_in = "x";
    repeat (3) tick();
    stream("llo");
    tick();
    chk("gap_cnt", match_cnt, 1);
    chk("gap_npulse", pulses - p0, 1);
    disarm();

    // Case folding
    mode_nocase = 1'b1;
    arm(5);
    stream("HeLLo");
    tick();
    chk("nocase_cnt", match_cnt, 1);
    disarm();
    mode_nocase = 1'b0;
    arm(5);
    p0 = pulses;
    stream("HeLLo");
    tick();
    chk("case_cnt", match_cnt, 0);
    chk("case_npulse", pulses - p0, 0);
    disarm();

    // Pattern writes ignored while running; symbol dropped when en falls with it
    arm(5);
    cfg_we = 1'b1; cfg_idx = '0; cfg_data = "j";
    tick();
    cfg_we = 1'b0;
    stream("hello");
    tick();
    chk("run_we_ignored", match_cnt, 1);
    p0 = pulses;
    stream("hell");
    data_in = "o"; data_in_valid = 1'b1; en = 1'b0;
    tick();
    data_in_valid = 1'b0;
    chk("drop_ok", check_ok, 0);
    tick();
    chk("drop_cnt", match_cnt, 1);
    chk("drop_npulse", pulses - p0, 0);

    // Reset mid-stream wipes the pattern
    arm(5);
    stream("hel");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rerst_cnt", match_cnt, 0);
    p0 = pulses;
    stream("lo");
    tick();
    chk("rerst_lo_cnt", match_cnt, 0);
    chk("rerst_lo_npulse", pulses - p0, 0);
    stream_byte(8'h00, 5);
    tick();
    chk("zero_pat_cnt", match_cnt, 1);
    disarm();

    // Bad lengths
    arm(0);
    chk("len0_err", cfg_err, 1);
    p0 = pulses;
    stream_byte(8'h00, 6);
    stream("lo");
    tick();
    chk("len0_npulse", pulses - p0, 0);
    disarm();
    chk("err_hold", cfg_err, 1);
    load("hello");
    arm(ML + 1);
    chk("lenbig_err", cfg_err, 1);
    p0 = pulses;
    stream("hellohello");
    tick();
    chk("lenbig_npulse", pulses - p0, 0);
    disarm();

    // Counter saturation: 17 overlapping matches of "aa"
    load("aa");
    mode_overlap = 1'b1;
    arm(2);
    chk("len2_err", cfg_err, 0);
    p0 = pulses;
    stream_byte(8'h61, 18);
    tick();
    chk("sat_cnt", match_cnt, CNT_MAX);
    chk("sat_npulse", pulses - p0, 17);
    disarm();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
